// File: rtl/gpr_busy_scoreboard_if.sv
// Purpose: request/response bundle between the issue stage and the GPR busy scoreboard.
//   master: issuer / decode side (drives set, clear and read requests)
//   slave : scoreboard side (returns set_ready and rd_busy)
// Signals:
//   set_valid/set_addr/set_size  per-port set requests (span 00=1, 01=2, 1x=4 words)
//   set_ready                    all valid sets accepted this cycle
//   clr_valid/clr_addr           per-port per-word clear mask and base register
//   rd_addr/rd_size/rd_busy      read base, span and per-word busy result
interface gpr_busy_scoreboard_if #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned NUM_SET = 3,
    parameter int unsigned NUM_CLR = 3,
    parameter int unsigned NUM_RD  = 6
) ();
    logic [NUM_SET-1:0]        set_valid;
    logic [NUM_SET*ADDR_W-1:0] set_addr;
    logic [NUM_SET*2-1:0]      set_size;
    logic                      set_ready;
    logic [NUM_CLR*4-1:0]      clr_valid;
    logic [NUM_CLR*ADDR_W-1:0] clr_addr;
    logic [NUM_RD*ADDR_W-1:0]  rd_addr;
    logic [NUM_RD*2-1:0]       rd_size;
    logic [NUM_RD*4-1:0]       rd_busy;

    modport master (
        output set_valid, set_addr, set_size, clr_valid, clr_addr, rd_addr, rd_size,
        input  set_ready, rd_busy
    );

    modport slave (
        input  set_valid, set_addr, set_size, clr_valid, clr_addr, rd_addr, rd_size,
        output set_ready, rd_busy
    );
endinterface

// File: rtl/gpr_busy_scoreboard.sv
// Purpose: per-register pending-write counters for the issue stage. Dispatch increments,
// retire decrements, decode reads a busy bit per word. Sets are all-or-nothing and back-pressure
// when any counter would exceed its maximum; clears are never stalled.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset
//   flush_i    zero all counters next cycle (sets refused, error flags untouched)
//   bus        gpr_busy_scoreboard_if.slave (set / clear / read ports)
//   idle_o     registered: every counter is zero
//   ovf_err_o  sticky: a counter would have exceeded its maximum
//   udf_err_o  sticky: a clear hit a zero counter
module gpr_busy_scoreboard #(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned NUM_SET = 3,
    parameter int unsigned NUM_CLR = 3,
    parameter int unsigned NUM_RD  = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    gpr_busy_scoreboard_if.slave bus,
    output logic                 idle_o,
    output logic                 ovf_err_o,
    output logic                 udf_err_o
);
    localparam int unsigned NumRegs  = 2 ** ADDR_W;
    localparam int unsigned CntMax   = 2 ** CNT_W - 1;
    localparam int unsigned MaxPorts = (NUM_SET > NUM_CLR) ? NUM_SET : NUM_CLR;
    localparam int unsigned HitW     = $clog2(MaxPorts + 1);
    // Wide enough to hold count + all sets and go negative after all clears.
    localparam int unsigned SumW     = CNT_W + HitW + 2;

    function automatic logic [3:0] span_mask(input logic [1:0] size);
        if (size[1])      return 4'b1111;
        else if (size[0]) return 4'b0011;
        else              return 4'b0001;
    endfunction

    logic [CNT_W-1:0]       cnt_q    [NumRegs];
    logic [CNT_W-1:0]       cnt_d    [NumRegs];
    logic [HitW-1:0]        set_hits [NumRegs];
    logic [HitW-1:0]        clr_hits [NumRegs];
    logic signed [SumW-1:0] sum;
    logic                   set_block, set_apply;
    logic                   idle_d, ovf_d, udf_d;
    logic                   idle_q, ovf_q, udf_q;

    // Per-word count of set ports and clear bits targeting it this cycle.
    always_comb begin : hit_count
        logic [3:0]        mask;
        logic [ADDR_W-1:0] w;
        mask = '0;
        w    = '0;
        for (int r = 0; r < NumRegs; r++) begin
            set_hits[r] = '0;
            clr_hits[r] = '0;
        end
        for (int p = 0; p < NUM_SET; p++) begin
            mask = span_mask(bus.set_size[2*p +: 2]);
            for (int k = 0; k < 4; k++) begin
                w = bus.set_addr[ADDR_W*p +: ADDR_W] + ADDR_W'(k);
                if (bus.set_valid[p] && mask[k]) set_hits[w] = set_hits[w] + HitW'(1);
            end
        end
        for (int p = 0; p < NUM_CLR; p++) begin
            for (int k = 0; k < 4; k++) begin
                w = bus.clr_addr[ADDR_W*p +: ADDR_W] + ADDR_W'(k);
                if (bus.clr_valid[4*p+k]) clr_hits[w] = clr_hits[w] + HitW'(1);
            end
        end
    end

    // Clears are deliberately ignored here: a set must fit even if the retire slips.
    always_comb begin : ready_calc
        set_block = 1'b0;
        for (int r = 0; r < NumRegs; r++) begin
            if (SumW'(cnt_q[r]) + SumW'(set_hits[r]) > SumW'(CntMax)) set_block = 1'b1;
        end
        set_apply     = !set_block && !flush_i;
        bus.set_ready = set_apply;
    end

    always_comb begin : next_state
        ovf_d  = 1'b0;
        udf_d  = 1'b0;
        idle_d = 1'b1;
        sum    = '0;
        for (int r = 0; r < NumRegs; r++) begin
            sum = $signed(SumW'(cnt_q[r])) + $signed(SumW'(set_hits[r] & {HitW{set_apply}}))
                - $signed(SumW'(clr_hits[r]));
            if (sum[SumW-1]) begin
                cnt_d[r] = '0;
                udf_d    = 1'b1;
            end else if (sum > $signed(SumW'(CntMax))) begin
                cnt_d[r] = CNT_W'(CntMax);
                ovf_d    = 1'b1;
            end else begin
                cnt_d[r] = sum[CNT_W-1:0];
            end
            if (flush_i) cnt_d[r] = '0;
            if (cnt_d[r] != '0) idle_d = 1'b0;
        end
        if (flush_i) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
    end

    // Reads see registered counters only; no bypass of same-cycle updates.
    always_comb begin : read_ports
        logic [3:0]        mask;
        logic [ADDR_W-1:0] w;
        mask        = '0;
        w           = '0;
        bus.rd_busy = '0;
        for (int q = 0; q < NUM_RD; q++) begin
            mask = span_mask(bus.rd_size[2*q +: 2]);
            for (int k = 0; k < 4; k++) begin
                w = bus.rd_addr[ADDR_W*q +: ADDR_W] + ADDR_W'(k);
                bus.rd_busy[4*q+k] = mask[k] && (cnt_q[w] != '0);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NumRegs; r++) cnt_q[r] <= '0;
            idle_q <= 1'b1;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NumRegs; r++) cnt_q[r] <= cnt_d[r];
            idle_q <= idle_d;
            ovf_q  <= ovf_q | ovf_d;
            udf_q  <= udf_q | udf_d;
        end
    end

    assign idle_o    = idle_q;
    assign ovf_err_o = ovf_q;
    assign udf_err_o = udf_q;
endmodule
